// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register pending
// (scoreboard) bit. Decode locks destinations and reads sources; writeback
// writes results and releases the lock on the written register.
//
// Parameters:
//   n      bits per register
//   k      address bits (2^k registers)
//   R      number of read ports (>= 1)
//   ZERO   1: register 0 reads as 0 and ignores writes/locks
//   BYPASS 1: same-cycle write data is forwarded to matching read ports
//
// Ports:
//   clk   clock, all state updates on posedge
//   rst   synchronous active-high reset (clears data and pending bits)
//   x     write data
//   ld    write enable: reg[d] <= x, pending[d] <= 0
//   d     write address
//   lk    lock request: pending[lkd] <= 1
//   lkd   lock address
//   lkb   pending[lkd] is already set (re-lock warning to the issuer)
//   s     read addresses, port i at s[i*k +: k]
//   q     read data, port i at q[i*n +: n]
//   rdy   per-port: read data is architecturally valid
module regfile_sb #(
  parameter int n      = 16,
  parameter int k      = 4,
  parameter int R      = 2,
  parameter int ZERO   = 0,
  parameter int BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-1:0]   x,
  input  logic           ld,
  input  logic [k-1:0]   d,
  input  logic           lk,
  input  logic [k-1:0]   lkd,
  output logic           lkb,
  input  logic [R*k-1:0] s,
  output logic [R*n-1:0] q,
  output logic [R-1:0]   rdy
);

  localparam int   NREG      = 1 << k;
  localparam logic ZERO_EN   = (ZERO != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [n-1:0]    regs [NREG];
  logic [NREG-1:0] pend;

  logic ld_ok;
  logic lk_ok;

  assign ld_ok = ld && !(ZERO_EN && d == '0);
  assign lk_ok = lk && !(ZERO_EN && lkd == '0);

  // The lock is applied after the release so that a same-cycle write and
  // lock of one register leaves it pending: the new producer supersedes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NREG; j++) regs[j] <= '0;
      pend <= '0;
    end else begin
      if (ld_ok) begin
        regs[d] <= x;
        pend[d] <= 1'b0;
      end
      if (lk_ok) pend[lkd] <= 1'b1;
    end
  end

  assign lkb = pend[lkd] && !(ZERO_EN && lkd == '0);

  for (genvar i = 0; i < R; i++) begin : g_rd
    logic [k-1:0] a;
    logic         zero_a;
    logic         hit;

    assign a      = s[i*k +: k];
    assign zero_a = ZERO_EN && a == '0;
    // Forwarding is suppressed during reset since the write will not land.
    assign hit    = BYPASS_EN && ld && d == a && !zero_a && !rst;

    assign q[i*n +: n] = hit ? x : (zero_a ? '0 : regs[a]);
    assign rdy[i]      = hit | !pend[a] | zero_a;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld, lk;
  logic [15:0] x;
  logic [3:0]  d, lkd, s0, s1, s2, s3;

  logic [31:0] q_a, q_b, q_c;
  logic [63:0] q_d;
  logic [1:0]  rdy_a, rdy_b, rdy_c;
  logic [3:0]  rdy_d;
  logic        lkb_a, lkb_b, lkb_c, lkb_d;

  regfile_sb #(.n(16), .k(4), .R(2), .ZERO(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .x(x), .ld(ld), .d(d), .lk(lk), .lkd(lkd),
    .lkb(lkb_a), .s({s1, s0}), .q(q_a), .rdy(rdy_a));

  regfile_sb #(.n(16), .k(4), .R(2), .ZERO(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .x(x), .ld(ld), .d(d), .lk(lk), .lkd(lkd),
    .lkb(lkb_b), .s({s1, s0}), .q(q_b), .rdy(rdy_b));

  regfile_sb #(.n(16), .k(4), .R(2), .ZERO(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .x(x), .ld(ld), .d(d), .lk(lk), .lkd(lkd),
    .lkb(lkb_c), .s({s1, s0}), .q(q_c), .rdy(rdy_c));

  regfile_sb #(.n(16), .k(4), .R(4), .ZERO(0), .BYPASS(1)) dut_d (
    .clk(clk), .rst(rst), .x(x), .ld(ld), .d(d), .lk(lk), .lkd(lkd),
    .lkb(lkb_d), .s({s3, s2, s1, s0}), .q(q_d), .rdy(rdy_d));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = plain register file, index 1 = hardwired r0.
  logic [15:0] m_reg  [2][16];
  logic        m_pend [2][16];
  logic        m_valid = 1'b0;

  function automatic logic [15:0] exp_q(input int z, input int byp, input logic [3:0] a);
    logic za;
    za = (z != 0) && (a == 4'd0);
    if (byp != 0 && ld && d == a && !za && !rst) return x;
    if (za) return 16'h0;
    return m_reg[z][a];
  endfunction

  function automatic logic exp_rdy(input int z, input int byp, input logic [3:0] a);
    logic za;
    za = (z != 0) && (a == 4'd0);
    if (byp != 0 && ld && d == a && !za && !rst) return 1'b1;
    return !m_pend[z][a] || za;
  endfunction

  function automatic logic exp_lkb(input int z);
    return m_pend[z][lkd] && !((z != 0) && lkd == 4'd0);
  endfunction

  task automatic model_update();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int j = 0; j < 16; j++) begin
          m_reg[z][j]  = 16'h0;
          m_pend[z][j] = 1'b0;
        end
      end else begin
        if (ld && !(z != 0 && d == 4'd0)) begin
          m_reg[z][d]  = x;
          m_pend[z][d] = 1'b0;
        end
        if (lk && !(z != 0 && lkd == 4'd0)) m_pend[z][lkd] = 1'b1;
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic check_models();
    logic [3:0] sa [4];
    sa[0] = s0; sa[1] = s1; sa[2] = s2; sa[3] = s3;
    if (!m_valid) return;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("b_q%0d", p),   32'(q_b[p*16 +: 16]), 32'(exp_q(0, 0, sa[p])));
      chk($sformatf("b_rdy%0d", p), 32'(rdy_b[p]),       32'(exp_rdy(0, 0, sa[p])));
      chk($sformatf("c_q%0d", p),   32'(q_c[p*16 +: 16]), 32'(exp_q(1, 1, sa[p])));
      chk($sformatf("c_rdy%0d", p), 32'(rdy_c[p]),       32'(exp_rdy(1, 1, sa[p])));
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("d_q%0d", p),   32'(q_d[p*16 +: 16]), 32'(exp_q(0, 1, sa[p])));
      chk($sformatf("d_rdy%0d", p), 32'(rdy_d[p]),       32'(exp_rdy(0, 1, sa[p])));
    end
    chk("b_lkb", 32'(lkb_b), 32'(exp_lkb(0)));
    chk("c_lkb", 32'(lkb_c), 32'(exp_lkb(1)));
    chk("d_lkb", 32'(lkb_d), 32'(exp_lkb(0)));
  endtask

  // Inputs are applied, settle 2 time units, then checked before the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rst, ld;
    logic [3:0]  d;
    logic [15:0] x;
    logic        lk;
    logic [3:0]  lkd, s0, s1;
    logic [15:0] q0, q1;
    logic [1:0]  rdy;
    logic        lkb;
    logic        chk;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] dd,
                              input logic [15:0] xx, input logic kk, input logic [3:0] kd,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [1:0] er, input logic el, input logic c);
    vec_t v;
    v.rst = r; v.ld = l; v.d = dd; v.x = xx; v.lk = kk; v.lkd = kd;
    v.s0 = a0; v.s1 = a1; v.q0 = e0; v.q1 = e1; v.rdy = er; v.lkb = el; v.chk = c;
    return v;
  endfunction

  vec_t vt [20];

  initial begin
    // Expected values are for dut_a (R=2, BYPASS=1, ZERO=0), same-cycle view.
    //            rst ld d   x        lk lkd s0  s1  q0       q1       rdy    lkb chk
    vt[0]  = mk(1, 0, 0,  16'h0000, 0, 0,  0,  0,  16'h0000, 16'h0000, 2'b11, 0, 0);
    vt[1]  = mk(0, 1, 5,  16'hBEEF, 1, 7,  5,  7,  16'hBEEF, 16'h0000, 2'b11, 0, 1);
    vt[2]  = mk(0, 0, 0,  16'h0000, 0, 7,  5,  7,  16'hBEEF, 16'h0000, 2'b01, 1, 1);
    vt[3]  = mk(1, 1, 5,  16'h1111, 0, 7,  5,  7,  16'hBEEF, 16'h0000, 2'b01, 1, 1);
    vt[4]  = mk(0, 0, 0,  16'h0000, 0, 7,  5,  7,  16'h0000, 16'h0000, 2'b11, 0, 1);
    vt[5]  = mk(0, 1, 3,  16'h1234, 0, 0,  3,  3,  16'h1234, 16'h1234, 2'b11, 0, 1);
    vt[6]  = mk(0, 0, 0,  16'h0000, 1, 9,  3,  9,  16'h1234, 16'h0000, 2'b11, 0, 1);
    vt[7]  = mk(0, 0, 0,  16'h0000, 0, 9,  3,  9,  16'h1234, 16'h0000, 2'b01, 1, 1);
    vt[8]  = mk(0, 1, 9,  16'h00AA, 0, 9,  9,  9,  16'h00AA, 16'h00AA, 2'b11, 1, 1);
    vt[9]  = mk(0, 0, 0,  16'h0000, 0, 9,  3,  9,  16'h1234, 16'h00AA, 2'b11, 0, 1);
    vt[10] = mk(0, 1, 4,  16'h5555, 1, 4,  4,  3,  16'h5555, 16'h1234, 2'b11, 0, 1);
    vt[11] = mk(0, 0, 0,  16'h0000, 0, 4,  4,  4,  16'h5555, 16'h5555, 2'b00, 1, 1);
    vt[12] = mk(0, 1, 2,  16'h0F0F, 1, 6,  2,  6,  16'h0F0F, 16'h0000, 2'b11, 0, 1);
    vt[13] = mk(0, 0, 0,  16'h0000, 0, 6,  2,  6,  16'h0F0F, 16'h0000, 2'b01, 1, 1);
    vt[14] = mk(0, 1, 4,  16'hAAAA, 1, 6,  6,  4,  16'h0000, 16'hAAAA, 2'b10, 1, 1);
    vt[15] = mk(0, 0, 0,  16'h0000, 0, 4,  4,  6,  16'hAAAA, 16'h0000, 2'b01, 0, 1);
    vt[16] = mk(0, 1, 0,  16'h7777, 0, 0,  0,  15, 16'h7777, 16'h0000, 2'b11, 0, 1);
    vt[17] = mk(0, 0, 0,  16'h0000, 0, 0,  0,  0,  16'h7777, 16'h7777, 2'b11, 0, 1);
    vt[18] = mk(0, 1, 15, 16'hC3C3, 1, 0,  15, 0,  16'hC3C3, 16'h7777, 2'b11, 0, 1);
    vt[19] = mk(0, 0, 0,  16'h0000, 0, 0,  15, 0,  16'hC3C3, 16'h7777, 2'b01, 1, 1);

    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; ld = vt[i].ld; d = vt[i].d; x = vt[i].x;
      lk = vt[i].lk; lkd = vt[i].lkd; s0 = vt[i].s0; s1 = vt[i].s1;
      s2 = vt[i].s1; s3 = vt[i].s0;
      #2;
      if (vt[i].chk) begin
        chk($sformatf("v%0d_q0", i),  32'(q_a[15:0]),  32'(vt[i].q0));
        chk($sformatf("v%0d_q1", i),  32'(q_a[31:16]), 32'(vt[i].q1));
        chk($sformatf("v%0d_rdy", i), 32'(rdy_a),      32'(vt[i].rdy));
        chk($sformatf("v%0d_lkb", i), 32'(lkb_a),      32'(vt[i].lkb));
      end
      check_models();
      tick();
    end

    // Write latency: BYPASS=0 shows the old value in the ld cycle.
    rst = 0; lk = 0; lkd = 0; ld = 1; d = 3; x = 16'h4321;
    s0 = 3; s1 = 3; s2 = 3; s3 = 3;
    #2;
    chk("lat_b_old",  32'(q_b[15:0]), 32'h1234);
    chk("lat_a_byp",  32'(q_a[15:0]), 32'h4321);
    chk("lat_a_rdy",  32'(rdy_a[0]),  32'h1);
    check_models();
    tick();
    ld = 0;
    #2;
    chk("lat_b_new",  32'(q_b[15:0]), 32'h4321);
    check_models();
    tick();

    // Hardwired zero: writes and locks to r0 are ignored.
    ld = 1; d = 0; x = 16'hFFFF; lk = 1; lkd = 0; s0 = 0; s1 = 0;
    #2;
    chk("zero_q_ld",   32'(q_c),   32'h0);
    chk("zero_rdy_ld", 32'(rdy_c), 32'h3);
    chk("zero_lkb_ld", 32'(lkb_c), 32'h0);
    check_models();
    tick();
    ld = 0; lk = 0;
    #2;
    chk("zero_q_after",   32'(q_c),   32'h0);
    chk("zero_rdy_after", 32'(rdy_c), 32'h3);
    chk("zero_lkb_after", 32'(lkb_c), 32'h0);
    check_models();
    tick();

    // Random ld/lk traffic with distinct, identical and random read addresses.
    for (int c = 0; c < 400; c++) begin
      int mode;
      rst = ($urandom_range(0, 63) == 0);
      ld  = $urandom_range(0, 1) == 1;
      lk  = $urandom_range(0, 1) == 1;
      x   = 16'($urandom);
      d   = $urandom_range(0, 1) == 1 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      lkd = $urandom_range(0, 1) == 1 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        s0 = 4'($urandom_range(0, 3)); s1 = s0; s2 = s0; s3 = s0;
      end else if (mode == 1) begin
        s0 = 4'($urandom_range(0, 3));
        s1 = s0 + 4'd1; s2 = s0 + 4'd2; s3 = s0 + 4'd3;
      end else begin
        s0 = 4'($urandom); s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
      end
      #2;
      check_models();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
